// File: rtl/sdram_bist_sequencer.sv
// sdram_bist_sequencer: SDRAM write/read-back self-test with error count and LED nibble display; SDRAM_BIST_ERRINJ_EN adds Inject_Sig
module sdram_bist_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 22,
  parameter int START_ADDR = 0,
  parameter int END_ADDR = 15,
  parameter logic [DATA_W-1:0] CONST_PAT = 16'h1248,
  parameter int ERR_W = 16,
  parameter int LED_W = 4,
  parameter int DISP_DELAY = 20000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_Sig,
`ifdef SDRAM_BIST_ERRINJ_EN
  input  logic              Inject_Sig,
`endif
  input  logic [1:0]        Mode,
  input  logic              Busy_Sig,
  input  logic              Done_Sig,
  input  logic [DATA_W-1:0] RdData,
  output logic              WrEN_Sig,
  output logic              RdEN_Sig,
  output logic [ADDR_W-1:0] BRC_Addr,
  output logic [DATA_W-1:0] WrData,
  output logic              Test_Done,
  output logic              Pass,
  output logic [ERR_W-1:0]  Err_Count,
  output logic [ADDR_W-1:0] First_Err_Addr,
  output logic [LED_W-1:0]  LED
);
  localparam int NIB = (ERR_W + LED_W - 1) / LED_W;
  localparam int PW = NIB * LED_W;
  localparam int NW = NIB > 1 ? $clog2(NIB) : 1;
  localparam int CW = DISP_DELAY > 1 ? $clog2(DISP_DELAY) : 1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_WGAP, S_READ, S_RGAP, S_DISP} state_t;
  state_t            r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_addr, r_brc, r_first;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wren, r_rden, r_done, r_pass;
  logic [ERR_W-1:0]  r_err;
  logic [LED_W-1:0]  r_led;
  logic [CW-1:0]     r_cnt;
  logic [NW-1:0]     r_nib;
  logic [DATA_W-1:0] w_wpat, w_rpat;
  logic [PW-1:0]     w_err_pad;
  logic [NW-1:0]     w_nib_nx;
  logic              w_last, w_mis;
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] ad);
    logic [DATA_W-1:0] a;
    a = DATA_W'(ad);
    return m == 2'd0 ? a : m == 2'd1 ? ~a : m == 2'd2 ? DATA_W'(1) << (a % DATA_W'(DATA_W)) : CONST_PAT;
  endfunction
`ifdef SDRAM_BIST_ERRINJ_EN
  logic r_inj;
  // Flipping bit 0 of the first write proves the comparator can see a mismatch.
  assign w_wpat = pat(r_mode, r_addr) ^ DATA_W'(r_inj && r_addr == ADDR_W'(START_ADDR));
`else
  assign w_wpat = pat(r_mode, r_addr);
`endif
  assign w_rpat = pat(r_mode, r_addr);
  assign w_mis = RdData != w_rpat;
  assign w_last = r_addr == ADDR_W'(END_ADDR);
  assign w_err_pad = PW'(r_err);
  assign w_nib_nx = r_nib == NW'(NIB - 1) ? '0 : r_nib + NW'(1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_mode <= '0;
      r_addr <= '0;
      r_brc <= '0;
      r_first <= '0;
      r_wdata <= '0;
      r_wren <= 1'b0;
      r_rden <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err <= '0;
      r_led <= '0;
      r_cnt <= '0;
      r_nib <= '0;
`ifdef SDRAM_BIST_ERRINJ_EN
      r_inj <= 1'b0;
`endif
    end else if (Start_Sig && (r_state == S_IDLE || r_state == S_DISP)) begin
      r_state <= S_WAIT;
      r_mode <= Mode;
      r_addr <= ADDR_W'(START_ADDR);
      r_err <= '0;
      r_first <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
`ifdef SDRAM_BIST_ERRINJ_EN
      r_inj <= Inject_Sig;
`endif
    end else begin
      case (r_state)
        S_WAIT: if (!Busy_Sig) r_state <= S_WRITE;
        // Requests only rise while the SDRAM is free and no stale Done is on the bus.
        S_WRITE: if (!r_wren) begin
          if (!Busy_Sig && !Done_Sig) begin
            r_wren <= 1'b1;
            r_brc <= r_addr;
            r_wdata <= w_wpat;
          end
        end else if (Done_Sig) begin
          r_wren <= 1'b0;
          r_state <= S_WGAP;
        end
        S_WGAP: begin
          r_addr <= w_last ? ADDR_W'(START_ADDR) : r_addr + ADDR_W'(1);
          r_state <= w_last ? S_READ : S_WRITE;
        end
        S_READ: if (!r_rden) begin
          if (!Busy_Sig && !Done_Sig) begin
            r_rden <= 1'b1;
            r_brc <= r_addr;
          end
        end else if (Done_Sig) begin
          r_rden <= 1'b0;
          r_state <= S_RGAP;
          if (w_mis && ~&r_err) r_err <= r_err + ERR_W'(1);
          if (w_mis && r_err == '0) r_first <= r_addr;
        end
        S_RGAP: if (w_last) begin
          r_done <= 1'b1;
          r_pass <= r_err == '0;
          r_state <= S_DISP;
          r_nib <= '0;
          r_cnt <= '0;
          r_led <= w_err_pad[LED_W-1:0];
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
          r_state <= S_READ;
        end
        S_DISP: if (r_cnt == CW'(DISP_DELAY - 1)) begin
          r_cnt <= '0;
          r_nib <= w_nib_nx;
          r_led <= w_err_pad[w_nib_nx*LED_W +: LED_W];
        end else r_cnt <= r_cnt + CW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign WrEN_Sig = r_wren;
  assign RdEN_Sig = r_rden;
  assign BRC_Addr = r_brc;
  assign WrData = r_wdata;
  assign Test_Done = r_done;
  assign Pass = r_pass;
  assign Err_Count = r_err;
  assign First_Err_Addr = r_first;
  assign LED = r_led;
endmodule

// File: tb/tb_sdram_bist_sequencer.sv
// tb_sdram_bist_sequencer: vector table plus hand sequences against an ideal 3-cycle SDRAM model
module tb_sdram_bist_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start_Sig = 1'b0;
  logic [1:0]  Mode = 2'd0;
  logic        Busy_Sig = 1'b0;
  logic        Done_Sig = 1'b0;
  logic [15:0] RdData = 16'h0;
  logic        WrEN_Sig, RdEN_Sig, Test_Done, Pass;
  logic [21:0] BRC_Addr, First_Err_Addr;
  logic [15:0] WrData, Err_Count;
  logic [3:0]  LED;
`ifdef SDRAM_BIST_ERRINJ_EN
  logic        Inject_Sig = 1'b0;
`endif
  logic [15:0] mem [0:15];
  logic [15:0] wlog [0:3];
  int          wcnt = 0, rcnt = 0, lat = 0;
  logic        flip2 = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  sdram_bist_sequencer #(.START_ADDR(0), .END_ADDR(3), .DISP_DELAY(4)) dut (
    .CLK(CLK), .RST(RST), .Start_Sig(Start_Sig),
`ifdef SDRAM_BIST_ERRINJ_EN
    .Inject_Sig(Inject_Sig),
`endif
    .Mode(Mode), .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig), .RdData(RdData),
    .WrEN_Sig(WrEN_Sig), .RdEN_Sig(RdEN_Sig), .BRC_Addr(BRC_Addr), .WrData(WrData),
    .Test_Done(Test_Done), .Pass(Pass), .Err_Count(Err_Count),
    .First_Err_Addr(First_Err_Addr), .LED(LED)
  );

  always #5 CLK = ~CLK;

  // Ideal SDRAM: Done pulses on the third cycle of a request, stalling while Busy is high.
  always @(negedge CLK) begin
    if (RST || !(WrEN_Sig || RdEN_Sig)) begin
      Done_Sig = 1'b0;
      lat = 0;
    end else if (Done_Sig) Done_Sig = 1'b0;
    else if (!Busy_Sig) begin
      if (lat == 2) begin
        Done_Sig = 1'b1;
        lat = 0;
        if (WrEN_Sig) begin
          mem[BRC_Addr[3:0]] = WrData;
          if (BRC_Addr < 22'd4) wlog[BRC_Addr[1:0]] = WrData;
          wcnt++;
        end else begin
          RdData = mem[BRC_Addr[3:0]] ^ ((flip2 && BRC_Addr == 22'd2) ? 16'h0004 : 16'h0000);
          rcnt++;
        end
      end else lat++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] m);
    Mode = m;
    Start_Sig = 1'b1;
    tick();
    Start_Sig = 1'b0;
    Mode = 2'd3;
    chk("start_clears_done", {31'd0, Test_Done}, 32'd0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!Test_Done && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, {31'd0, Test_Done}, 32'd1);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_wren"}, {31'd0, WrEN_Sig}, 32'd0);
    chk({nm, "_rden"}, {31'd0, RdEN_Sig}, 32'd0);
    chk({nm, "_addr"}, {10'd0, BRC_Addr}, 32'd0);
    chk({nm, "_wdata"}, {16'd0, WrData}, 32'd0);
    chk({nm, "_done"}, {31'd0, Test_Done}, 32'd0);
    chk({nm, "_pass"}, {31'd0, Pass}, 32'd0);
    chk({nm, "_err"}, {16'd0, Err_Count}, 32'd0);
    chk({nm, "_first"}, {10'd0, First_Err_Addr}, 32'd0);
    chk({nm, "_led"}, {28'd0, LED}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic             flip;
    logic             pass;
    logic [15:0]      err;
    logic [21:0]      first;
    logic [3:0]       led;
    logic [3:0][15:0] wp;
  } vec_t;
  vec_t vt [6];

  initial begin
    int w0, r0, n, lo;
    vt[0] = '{2'd0, 1'b0, 1'b1, 16'd0, 22'd0, 4'd0, {16'h0003, 16'h0002, 16'h0001, 16'h0000}};
    vt[1] = '{2'd0, 1'b1, 1'b0, 16'd1, 22'd2, 4'd1, {16'h0003, 16'h0002, 16'h0001, 16'h0000}};
    vt[2] = '{2'd1, 1'b0, 1'b1, 16'd0, 22'd0, 4'd0, {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}};
    vt[3] = '{2'd2, 1'b0, 1'b1, 16'd0, 22'd0, 4'd0, {16'h0008, 16'h0004, 16'h0002, 16'h0001}};
    vt[4] = '{2'd3, 1'b1, 1'b0, 16'd1, 22'd2, 4'd1, {16'h1248, 16'h1248, 16'h1248, 16'h1248}};
    vt[5] = '{2'd1, 1'b1, 1'b0, 16'd1, 22'd2, 4'd1, {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}};
    repeat (3) tick();
    chk_outs_zero("reset");
    RST = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      flip2 = vt[i].flip;
      w0 = wcnt;
      r0 = rcnt;
      start(vt[i].mode);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_pass", i), {31'd0, Pass}, {31'd0, vt[i].pass});
      chk($sformatf("v%0d_err", i), {16'd0, Err_Count}, {16'd0, vt[i].err});
      chk($sformatf("v%0d_first", i), {10'd0, First_Err_Addr}, {10'd0, vt[i].first});
      chk($sformatf("v%0d_led", i), {28'd0, LED}, {28'd0, vt[i].led});
      chk($sformatf("v%0d_nwr", i), wcnt - w0, 32'd4);
      chk($sformatf("v%0d_nrd", i), rcnt - r0, 32'd4);
      for (int j = 0; j < 4; j++)
        chk($sformatf("v%0d_wdata%0d", i, j), {16'd0, wlog[j]}, {16'd0, vt[i].wp[j]});
    end
    // LED walks nibbles 1,0,0,0 of Err_Count=1, four cycles each, then restarts hold the LED.
    flip2 = 1'b1;
    start(2'd0);
    wait_done("ledseq");
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("led_k%0d", k), {28'd0, LED}, (k % 16) < 4 ? 32'd1 : 32'd0);
      if (k < 19) tick();
    end
    flip2 = 1'b0;
    start(2'd0);
    chk("led_hold_on_restart", {28'd0, LED}, 32'd1);
    wait_done("ledrestart");
    chk("ledrestart_pass", {31'd0, Pass}, 32'd1);
    chk("ledrestart_led", {28'd0, LED}, 32'd0);
    // Busy during startup and mid-read; a stray Start mid-test must be ignored.
    Busy_Sig = 1'b1;
    start(2'd0);
    lo = 0;
    repeat (100) begin
      tick();
      if (WrEN_Sig || RdEN_Sig) lo++;
    end
    chk("busy_no_enable", lo, 32'd0);
    Busy_Sig = 1'b0;
    n = 0;
    while (!RdEN_Sig && n < 500) begin
      tick();
      n++;
    end
    chk("busy_rden_seen", {31'd0, RdEN_Sig}, 32'd1);
    Busy_Sig = 1'b1;
    Mode = 2'd1;
    Start_Sig = 1'b1;
    lo = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      Start_Sig = 1'b0;
      if (!RdEN_Sig) lo++;
    end
    chk("busy_rden_held", lo, 32'd0);
    Busy_Sig = 1'b0;
    wait_done("busy");
    chk("busy_pass", {31'd0, Pass}, 32'd1);
    chk("busy_err", {16'd0, Err_Count}, 32'd0);
    chk("busy_wdata3", {16'd0, wlog[3]}, 32'h0003);
    // Reset in the middle of the write to address 1 aborts cleanly.
    start(2'd1);
    n = 0;
    while (!(WrEN_Sig && BRC_Addr == 22'd1) && n < 500) begin
      tick();
      n++;
    end
    chk("rst_wr1_seen", {31'd0, WrEN_Sig}, 32'd1);
    RST = 1'b1;
    tick();
    chk_outs_zero("midrst");
    RST = 1'b0;
    tick();
    w0 = wcnt;
    start(2'd0);
    wait_done("afterrst");
    chk("afterrst_pass", {31'd0, Pass}, 32'd1);
    chk("afterrst_nwr", wcnt - w0, 32'd4);
    chk("afterrst_wdata0", {16'd0, wlog[0]}, 32'h0000);
    chk("afterrst_wdata1", {16'd0, wlog[1]}, 32'h0001);
`ifdef SDRAM_BIST_ERRINJ_EN
    Inject_Sig = 1'b1;
    start(2'd3);
    Inject_Sig = 1'b0;
    wait_done("inject");
    chk("inject_wdata0", {16'd0, wlog[0]}, 32'h1249);
    chk("inject_wdata1", {16'd0, wlog[1]}, 32'h1248);
    chk("inject_err", {16'd0, Err_Count}, 32'd1);
    chk("inject_first", {10'd0, First_Err_Addr}, 32'd0);
    chk("inject_pass", {31'd0, Pass}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
